// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states, error codes and op legality helpers for the LSU.
package lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [1:0] E_MISALIGN = 2'b01;
    localparam logic [1:0] E_ILLEGAL  = 2'b10;
    localparam logic [1:0] E_TIMEOUT  = 2'b11;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f, input logic x64);
        return we ? (x64 ? f > F3_SD : f > F3_SW)
                  : (x64 ? f == 3'd7 : (f == F3_LD || f[2:1] == 2'b11));
    endfunction

    // access size is 1 << f[1:0] bytes; the offset must be a multiple of it
    function automatic logic misaligned(input logic [2:0] f, input logic [2:0] a);
        return (a & ((3'd1 << f[1:0]) - 3'd1)) != 3'd0;
    endfunction
endpackage

// File: rtl/lsu_lane_extractor.sv
// lsu_lane_extractor: load lane shift with sign/zero extension, store byte enables and lane replication.
module lsu_lane_extractor #(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  funct3,
    input  logic [$clog2(XLEN/8)-1:0]   lane,
    input  logic [XLEN-1:0]             rdata,
    input  logic [XLEN-1:0]             wdata,
    output logic [XLEN-1:0]             ldata,
    output logic [XLEN/8-1:0]           be,
    output logic [XLEN-1:0]             wdata_rep
);
    localparam int BW = XLEN / 8;
    localparam int LW = $clog2(XLEN);

    logic [XLEN-1:0] sh, mask;
    logic [LW-1:0]   msb;
    logic [BW-1:0]   bem;
    logic            sgn;

    always_comb begin
        sh        = rdata >> {lane, 3'b000};
        mask      = funct3[1:0] == 2'd0 ? XLEN'('hFF) :
                    funct3[1:0] == 2'd1 ? XLEN'('hFFFF) :
                    funct3[1:0] == 2'd2 ? XLEN'(32'hFFFF_FFFF) : '1;
        msb       = LW'((8 << funct3[1:0]) - 1);
        sgn       = ~funct3[2] & sh[msb];
        ldata     = (sh & mask) | ({XLEN{sgn}} & ~mask);
        bem       = BW'(funct3[1:0] == 2'd0 ? 1 : funct3[1:0] == 2'd1 ? 3 :
                        funct3[1:0] == 2'd2 ? 'hF : 'hFF);
        be        = bem << lane;
        wdata_rep = '0;
        // byte i of the bus carries operand byte (i mod access size)
        for (int i = 0; i < BW; i++)
            wdata_rep[i*8 +: 8] = wdata[(i & ((1 << funct3[1:0]) - 1))*8 +: 8];
    end
endmodule

// File: rtl/lsu_mem_handshake.sv
// lsu_mem_handshake: load/store unit driving a req/gnt/rvalid data-memory handshake and stalling the core.
module lsu_mem_handshake
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsu_valid,
    input  logic              lsu_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic              done,
    output logic [XLEN-1:0]   load_data,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int OFF = $clog2(XLEN / 8);
    localparam int CW  = $clog2(TIMEOUT + 1);

    logic [2:0]        state;
    logic              op_we;
    logic [2:0]        op_f3;
    logic [ADDR_W-1:0] op_addr;
    logic [XLEN-1:0]   op_wdata;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   ldata, wdata_rep;
    logic [XLEN/8-1:0] be;
    logic              ill, mis, capture;

    lsu_lane_extractor #(.XLEN(XLEN)) u_ext (
        .funct3    (op_f3),
        .lane      (op_addr[OFF-1:0]),
        .rdata     (mem_rdata),
        .wdata     (op_wdata),
        .ldata     (ldata),
        .be        (be),
        .wdata_rep (wdata_rep)
    );

    assign ill       = f3_illegal(lsu_we, funct3, XLEN == 64);
    assign mis       = misaligned(funct3, addr[2:0]);
    assign capture   = mem_rvalid & ((state == S_REQ & mem_gnt & ~op_we) | state == S_WAIT);
    assign stall     = state == S_IDLE ? lsu_valid : (state == S_REQ || state == S_WAIT);
    assign done      = state == S_DONE;
    assign err       = state == S_ERR;
    assign mem_req   = state == S_REQ;
    assign mem_we    = mem_req & op_we;
    assign mem_addr  = mem_req ? {op_addr[ADDR_W-1:OFF], {OFF{1'b0}}} : '0;
    assign mem_be    = mem_req ? be : '0;
    assign mem_wdata = mem_we ? wdata_rep : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_we     <= 1'b0;
            op_f3     <= '0;
            op_addr   <= '0;
            op_wdata  <= '0;
            cnt       <= '0;
            load_data <= '0;
            err_code  <= '0;
        end else begin
            case (state)
                S_IDLE: if (lsu_valid) begin
                    op_we    <= lsu_we;
                    op_f3    <= funct3;
                    op_addr  <= addr;
                    op_wdata <= wdata;
                    state    <= (ill | mis) ? S_ERR : S_REQ;
                    if (ill | mis)
                        err_code <= ill ? E_ILLEGAL : E_MISALIGN;
                end
                S_REQ: if (mem_gnt) begin
                    state <= (op_we | mem_rvalid) ? S_DONE : S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: if (mem_rvalid)
                    state <= S_DONE;
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    state    <= S_ERR;
                    err_code <= E_TIMEOUT;
                end else
                    cnt <= cnt + 1'b1;
                default: state <= S_IDLE;
            endcase
            if (capture)
                load_data <= ldata;
        end
    end
endmodule

// File: tb/tb_lsu_mem_handshake.sv
// tb_lsu_mem_handshake: directed load/store vectors against a cycle-schedule model of the LSU.
module tb_lsu_mem_handshake;
    localparam int TO = 16;

    logic        clk = 1'b0, reset;
    logic        lsu_valid, lsu_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, load_data, mem_addr, mem_wdata, mem_rdata;
    logic        stall, done, err, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [1:0]  err_code;
    logic [3:0]  mem_be;

    int checks = 0, failures = 0, cyc = 0;

    // active op description: accepted at t0, gnt after g waiting cycles, rvalid r cycles after gnt
    logic        act = 1'b0, o_we;
    logic [2:0]  o_f3;
    logic [31:0] o_addr, o_wd, o_rd, exp_ld = '0;
    logic [1:0]  code, exp_code = '0;
    int          t0, e, g, r;

    lsu_mem_handshake #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .lsu_valid(lsu_valid), .lsu_we(lsu_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .load_data(load_data),
        .err(err), .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, a, x);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        longint nb = longint'(1) << f[1:0];
        longint v  = (longint'(rd) >> (8 * a[1:0])) & ((longint'(1) << (8 * nb)) - 1);
        if (!f[2] && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
        return 4'(((1 << (1 << f[1:0])) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_rep(input logic [2:0] f, input logic [31:0] wd);
        return f[1:0] == 2'd0 ? (wd & 32'hFF) * 32'h0101_0101 :
               f[1:0] == 2'd1 ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    endfunction

    function automatic logic [1:0] m_code(input logic we, input logic [2:0] f, input logic [31:0] a);
        int nb = 1 << f[1:0];
        logic ill = we ? (f >= 3) : (f == 3 || f == 6 || f == 7);
        return ill ? 2'b10 : (int'(a[2:0]) % nb != 0) ? 2'b01 : 2'b00;
    endfunction

    // inputs for the current cycle follow from the op schedule
    task automatic drive();
        int rv_c = (r == 0) ? t0 + 1 + g : t0 + 1 + g + r;
        lsu_valid  = act && cyc >= t0 && cyc < e;
        mem_gnt    = act && (code == 0 || code == 3) && cyc == t0 + 1 + g;
        mem_rvalid = act && !o_we && code == 0 && cyc == rv_c;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_ld = '0;
            exp_code = '0;
            chk("rst_stall", stall, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
            chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0); chk("rst_addr", mem_addr, 0);
            chk("rst_be", mem_be, 0); chk("rst_wdata", mem_wdata, 0);
        end else begin
            logic inf, rq, fin;
            inf = act && cyc >= t0 && cyc < e;
            rq  = act && (code == 0 || code == 3) && cyc >= t0 + 1 && cyc <= t0 + 1 + g;
            fin = act && cyc == e;
            if (fin && code != 0) exp_code = code;
            if (fin && code == 0 && !o_we) exp_ld = m_load(o_f3, o_addr, o_rd);
            chk("stall", stall, inf);
            chk("done", done, fin && code == 0);
            chk("err", err, fin && code != 0);
            chk("mem_req", mem_req, rq);
            chk("mem_we", mem_we, rq && o_we);
            chk("mem_addr", mem_addr, rq ? o_addr & 32'hFFFF_FFFC : 32'h0);
            chk("mem_be", mem_be, rq ? m_be(o_f3, o_addr) : 4'h0);
            chk("mem_wdata", mem_wdata, (rq && o_we) ? m_rep(o_f3, o_wd) : 32'h0);
        end
        chk("load_data", load_data, exp_ld);
        chk("err_code", err_code, exp_code);
    end

    task automatic start_op(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int gd, input int rdly);
        @(posedge clk); #1;
        o_we = we; o_f3 = f; o_addr = a; o_wd = wd; o_rd = rd; g = gd; r = rdly;
        lsu_we = we; funct3 = f; addr = a; wdata = wd; mem_rdata = rd;
        code = m_code(we, f, a);
        t0 = cyc;
        if (code != 0) e = t0 + 1;
        else if (we || r == 0) e = t0 + 2 + g;
        else if (r <= TO) e = t0 + 2 + g + r;
        else begin code = 2'b11; e = t0 + 2 + g + TO; end
        act = 1'b1;
        drive();
    endtask

    task automatic run_op(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int gd, input int rdly, input logic [31:0] lit,
                          input logic [3:0] lbe, input logic [31:0] lwd);
        start_op(we, f, a, wd, rd, gd, rdly);
        while (cyc < e) begin
            @(posedge clk); #1;
            drive();
            if (cyc == t0 + 1 && we && code == 0) begin
                chk("lit_be", mem_be, lbe);
                chk("lit_wdata", mem_wdata, lwd);
            end
        end
        if (code != 0) begin
            chk("lit_code", err_code, lit);
            chk("model_code", code, lit);
        end else if (!we) begin
            chk("lit_load", load_data, lit);
            chk("model_load", m_load(f, a, rd), lit);
        end
        @(posedge clk); #1;
        act = 1'b0;
        drive();
    endtask

    initial begin
        reset = 1'b1; lsu_valid = 0; lsu_we = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_op(0, 3'd2, 32'h104, 0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0);
        run_op(0, 3'd0, 32'h103, 0, 32'h80FF_0000, 0, 1, 32'hFFFFFF80, 0, 0);
        run_op(0, 3'd4, 32'h103, 0, 32'h80FF_0000, 0, 1, 32'h00000080, 0, 0);
        run_op(0, 3'd5, 32'h102, 0, 32'h80FF_0000, 0, 1, 32'h000080FF, 0, 0);
        run_op(0, 3'd1, 32'h102, 0, 32'h80FF_0000, 1, 2, 32'hFFFF80FF, 0, 0);
        run_op(0, 3'd1, 32'h100, 0, 32'h0000_7FFF, 0, 0, 32'h00007FFF, 0, 0);
        run_op(0, 3'd2, 32'h108, 0, 32'h1234_5678, 0, 0, 32'h12345678, 0, 0);
        run_op(1, 3'd1, 32'h102, 32'h1234ABCD, 0, 0, 0, 0, 4'b1100, 32'hABCDABCD);
        run_op(1, 3'd0, 32'h101, 32'h00000055, 0, 0, 0, 0, 4'b0010, 32'h55555555);
        run_op(1, 3'd2, 32'h10C, 32'hCAFEF00D, 0, 5, 0, 0, 4'b1111, 32'hCAFEF00D);
        run_op(0, 3'd2, 32'h101, 0, 0, 0, 1, 32'h1, 0, 0);
        run_op(0, 3'd3, 32'h100, 0, 0, 0, 1, 32'h2, 0, 0);
        run_op(1, 3'd3, 32'h100, 0, 0, 0, 0, 32'h2, 0, 0);
        run_op(0, 3'd5, 32'h101, 0, 0, 0, 1, 32'h1, 0, 0);
        run_op(0, 3'd2, 32'h110, 0, 32'h1111_2222, 5, 99, 32'h3, 0, 0);
        run_op(0, 3'd2, 32'h114, 0, 32'hA5A5_A5A5, 0, TO, 32'hA5A5A5A5, 0, 0);
        // reset while the load sits in WAIT; a late rvalid afterwards must be ignored
        start_op(0, 3'd2, 32'h200, 0, 32'h7777_7777, 0, 99);
        repeat (3) begin @(posedge clk); #1; drive(); end
        #2;
        reset = 1'b1; act = 1'b0; lsu_valid = 0; mem_gnt = 0; mem_rvalid = 1;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_stall", stall, 0);
        chk("async_done", done, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 mem_rvalid = 0;
        run_op(0, 3'd2, 32'h120, 0, 32'h0F0F_0F0F, 0, 1, 32'h0F0F0F0F, 0, 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
